// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round counts, storage bound and the
// round-key store state encoding.
package aes_pkg;

    localparam int unsigned MAXNK = 15;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL,
        PLAY
    } rks_state_t;

    function automatic int unsigned nr_of(input int unsigned k);
        case (k)
            192:     return 12;
            256:     return 14;
            default: return 10;
        endcase
    endfunction

endpackage

// File: rtl/roundkey_store_if.sv
// Capture/replay bus of the round-key store: expander-side capture inputs,
// replay control and the valid/ready key output stream.
interface roundkey_store_if;

    logic         load;
    logic         key_valid;
    logic [127:0] key_in;
    logic         start;
    logic         dir;
    logic         out_ready;
    logic         out_valid;
    logic [127:0] out_key;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         full;
    logic         busy;
    logic         err;

    modport slave (
        input  load, key_valid, key_in, start, dir, out_ready,
        output out_valid, out_key, out_idx, out_last, full, busy, err
    );

    modport master (
        output load, key_valid, key_in, start, dir, out_ready,
        input  out_valid, out_key, out_idx, out_last, full, busy, err
    );

endinterface

// File: rtl/rk_regfile.sv
// Round-key register array: one write port and one registered read port whose
// output register can be cleared so an idle replay stream presents zero.
module rk_regfile #(
    parameter int unsigned Depth = 11
) (
    input  logic         clk,
    input  logic         i_we,
    input  logic [3:0]   i_waddr,
    input  logic [127:0] i_wdata,
    input  logic         i_re,
    input  logic         i_clr,
    input  logic [3:0]   i_raddr,
    output logic [127:0] o_rdata
);

    logic [127:0] r_mem [Depth];
    logic [127:0] r_rdata;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/roundkey_store.sv
// Captures the NR+1 round keys from the key expander once per key load and
// replays them forward or reverse through a valid/ready stream on demand.
module roundkey_store
    import aes_pkg::*;
#(
    parameter int unsigned K = 128
) (
    input logic              clk,
    input logic              reset_n,
    roundkey_store_if.slave  io_bus
);

    localparam int unsigned NR      = nr_of(K);
    localparam int unsigned NK      = NR + 1;
    localparam logic [3:0]  LastIdx = 4'(NR);

    generate
        if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
            $error("roundkey_store: K must be 128, 192 or 256");
        end
    endgenerate

    rks_state_t   r_state;
    logic [3:0]   r_wcnt;
    logic [3:0]   r_idx;
    logic         r_dir;
    logic         r_out_valid;
    logic [3:0]   r_out_idx;
    logic         r_out_last;
    logic         r_full;
    logic         r_busy;
    logic         r_err;

    logic         w_hs;
    logic         w_we;
    logic         w_re;
    logic         w_clr;
    logic [3:0]   w_raddr;
    logic [3:0]   w_next_idx;
    logic [127:0] w_rdata;

    // The read port is registered, so its address is the index the outputs will
    // show next cycle: the pass start index on start, the stepped index on handshake.
    always_comb begin
        w_hs       = (r_state == PLAY) && io_bus.out_ready;
        w_next_idx = r_dir ? (r_idx - 4'd1) : (r_idx + 4'd1);
        w_we       = reset_n && !io_bus.load && (r_state == FILL) && io_bus.key_valid;
        w_clr      = !reset_n || io_bus.load || (w_hs && r_out_last);
        w_re       = 1'b0;
        w_raddr    = r_idx;
        if ((r_state == FULL) && io_bus.start) begin
            w_re    = 1'b1;
            w_raddr = io_bus.dir ? LastIdx : 4'd0;
        end else if (w_hs && !r_out_last) begin
            w_re    = 1'b1;
            w_raddr = w_next_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= EMPTY;
            r_wcnt      <= 4'd0;
            r_idx       <= 4'd0;
            r_dir       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= 4'd0;
            r_out_last  <= 1'b0;
            r_full      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else if (io_bus.load) begin
            // Load overrides everything, including a pending replay key.
            r_state     <= FILL;
            r_wcnt      <= 4'd0;
            r_idx       <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_idx   <= 4'd0;
            r_out_last  <= 1'b0;
            r_full      <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            if (io_bus.key_valid && (r_state != FILL)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                EMPTY: ;
                FILL: begin
                    if (io_bus.key_valid) begin
                        r_wcnt <= r_wcnt + 4'd1;
                        if (r_wcnt == LastIdx) begin
                            r_state <= FULL;
                            r_full  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    if (io_bus.start) begin
                        r_state     <= PLAY;
                        r_dir       <= io_bus.dir;
                        r_idx       <= io_bus.dir ? LastIdx : 4'd0;
                        r_out_idx   <= io_bus.dir ? LastIdx : 4'd0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_full      <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                PLAY: begin
                    if (io_bus.out_ready) begin
                        if (r_out_last) begin
                            r_state     <= FULL;
                            r_out_valid <= 1'b0;
                            r_out_idx   <= 4'd0;
                            r_out_last  <= 1'b0;
                            r_full      <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_out_idx  <= w_next_idx;
                            r_out_last <= r_dir ? (w_next_idx == 4'd0)
                                                : (w_next_idx == LastIdx);
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    rk_regfile #(
        .Depth (NK)
    ) u_regfile (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wcnt),
        .i_wdata (io_bus.key_in),
        .i_re    (w_re),
        .i_clr   (w_clr),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_key   = w_rdata;
    assign io_bus.out_idx   = r_out_idx;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.full      = r_full;
    assign io_bus.busy      = r_busy;
    assign io_bus.err       = r_err;

endmodule

// File: tb/tb_roundkey_store.sv
// Bench for roundkey_store: an AES-128 and an AES-256 instance share stimulus;
// a key-array model predicts replay order from the capture history.
module tb_roundkey_store;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load, key_valid, start, dir, out_ready;
    logic [127:0] key_in;
    bit           sel;  // 0 observes the AES-128 instance, 1 the AES-256 one

    always #5 clk = ~clk;

    roundkey_store_if b128 ();
    roundkey_store_if b256 ();

    assign b128.load = load;      assign b256.load = load;
    assign b128.key_valid = key_valid; assign b256.key_valid = key_valid;
    assign b128.key_in = key_in;  assign b256.key_in = key_in;
    assign b128.start = start;    assign b256.start = start;
    assign b128.dir = dir;        assign b256.dir = dir;
    assign b128.out_ready = out_ready; assign b256.out_ready = out_ready;

    roundkey_store #(.K(128)) dut128 (.clk(clk), .reset_n(reset_n), .io_bus(b128));
    roundkey_store #(.K(256)) dut256 (.clk(clk), .reset_n(reset_n), .io_bus(b256));

    logic         w_valid, w_last, w_full, w_busy, w_err;
    logic [127:0] w_key;
    logic [3:0]   w_idx;
    assign w_valid = sel ? b256.out_valid : b128.out_valid;
    assign w_key   = sel ? b256.out_key   : b128.out_key;
    assign w_idx   = sel ? b256.out_idx   : b128.out_idx;
    assign w_last  = sel ? b256.out_last  : b128.out_last;
    assign w_full  = sel ? b256.full      : b128.full;
    assign w_busy  = sel ? b256.busy      : b128.busy;
    assign w_err   = sel ? b256.err       : b128.err;

    int checks = 0;
    int failures = 0;

    logic [127:0] fips [11] = '{
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5};

    // Model: what each instance should hold, slot = round index.
    logic [127:0] mem_m [2][16];

    logic [127:0] ob_key [32];
    logic [3:0]   ob_idx [32];
    logic         ob_last [32];
    int           ob_n, ob_cycles, ob_lat, ob_stall_viol, ob_zero_viol, cap_full_early;
    bit           ob_timeout;

    function automatic int nr_sel();
        return sel ? 14 : 10;
    endfunction

    // Stimulus: load, then nk keys with random idle gaps of 0..maxgap cycles.
    task automatic capture(input int nk, input int maxgap, input bit use_fips);
        logic [127:0] k;
        int g;
        cap_full_early = 0;
        load = 1'b1; key_valid = 1'b0;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < nk; i++) begin
            g = $urandom_range(maxgap, 0);
            repeat (g) begin
                if (w_full) cap_full_early++;
                @(negedge clk);
            end
            if (w_full) cap_full_early++;
            k = use_fips ? fips[i % 11] : {$urandom, $urandom, $urandom, $urandom};
            mem_m[sel][i] = k;
            key_valid = 1'b1; key_in = k;
            @(negedge clk);
            key_valid = 1'b0;
        end
    endtask

    // Stimulus + recorder: start one pass, log every handshake and stall behaviour.
    task automatic collect_pass(input bit d, input bit bp);
        logic [127:0] pk;
        logic [3:0]   pi;
        logic         pl;
        bit           prev_stall, done;
        int           cyc;
        ob_n = 0; ob_stall_viol = 0; ob_zero_viol = 0; ob_lat = -1;
        prev_stall = 0; done = 0; cyc = 0; pk = '0; pi = '0; pl = 1'b0;
        start = 1'b1; dir = d; out_ready = 1'b1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            out_ready = bp ? (((cyc - 1) % 3) == 0) : 1'b1;
            if (prev_stall && (w_valid !== 1'b1 || w_key !== pk || w_idx !== pi || w_last !== pl))
                ob_stall_viol++;
            if (!w_valid && w_key !== '0) ob_zero_viol++;
            if (w_valid && ob_lat < 0) ob_lat = cyc;
            if (w_valid && out_ready && ob_n < 32) begin
                ob_key[ob_n] = w_key; ob_idx[ob_n] = w_idx; ob_last[ob_n] = w_last;
                ob_n++;
                if (w_last) done = 1;
            end
            prev_stall = w_valid && !out_ready;
            pk = w_key; pi = w_idx; pl = w_last;
        end
        ob_timeout = !done;
        ob_cycles = cyc;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load = 0; key_valid = 0; start = 0; dir = 0; out_ready = 0;
        key_in = '0; sel = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", w_valid); end
        checks++; if (w_key !== '0) begin failures++; $display("FAIL reset_key got=%h exp=0", w_key); end
        checks++; if (w_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", w_idx); end
        checks++; if (w_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", w_last); end
        checks++; if (w_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", w_full); end
        checks++; if (w_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", w_busy); end
        checks++; if (w_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", w_err); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL empty_start got=%0b exp=0", w_valid); end
    endtask

    task automatic test_fwd128();
        sel = 0;
        capture(11, 0, 1);
        checks++; if (w_full !== 1'b1 || cap_full_early !== 0) begin failures++;
            $display("FAIL fwd_full got=%0b early=%0d exp=1,0", w_full, cap_full_early); end
        collect_pass(0, 0);
        checks++; if (ob_timeout || ob_n !== 11) begin failures++; $display("FAIL fwd_count got=%0d exp=11", ob_n); end
        checks++; if (ob_lat !== 1 || ob_cycles !== 11) begin failures++;
            $display("FAIL fwd_timing lat=%0d cycles=%0d exp=1,11", ob_lat, ob_cycles); end
        for (int i = 0; i < ob_n && i < 11; i++) begin
            checks++;
            if (ob_key[i] !== fips[i] || ob_idx[i] !== 4'(i) || ob_last[i] !== (i == 10)) begin
                failures++;
                $display("FAIL fwd_key%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i, ob_key[i], ob_idx[i],
                         ob_last[i], fips[i], i, i == 10);
            end
        end
        @(negedge clk);
        checks++; if (w_full !== 1'b1 || w_busy !== 1'b0 || w_valid !== 1'b0 || w_key !== '0) begin
            failures++; $display("FAIL fwd_after full=%0b busy=%0b valid=%0b exp=1,0,0", w_full, w_busy, w_valid); end
        // Start in the very cycle full is back: next pass follows with no extra bubble.
        collect_pass(1, 0);
        checks++; if (ob_lat !== 1 || ob_n !== 11 || ob_key[0] !== fips[10]) begin failures++;
            $display("FAIL b2b lat=%0d n=%0d key0=%h exp=1,11,%h", ob_lat, ob_n, ob_key[0], fips[10]); end
        @(negedge clk);
    endtask

    task automatic test_rev_backpressure();
        int e;
        sel = 0;
        collect_pass(1, 1);
        checks++; if (ob_timeout || ob_n !== 11) begin failures++; $display("FAIL rev_count got=%0d exp=11", ob_n); end
        checks++; if (ob_stall_viol !== 0 || ob_zero_viol !== 0) begin failures++;
            $display("FAIL rev_stable stall=%0d zero=%0d exp=0,0", ob_stall_viol, ob_zero_viol); end
        checks++; if (ob_cycles !== 31) begin failures++; $display("FAIL rev_cycles got=%0d exp=31", ob_cycles); end
        for (int i = 0; i < ob_n && i < 11; i++) begin
            e = 10 - i;
            checks++;
            if (ob_key[i] !== mem_m[0][e] || ob_idx[i] !== 4'(e) || ob_last[i] !== (i == 10)) begin
                failures++;
                $display("FAIL rev_key%0d got=%h/%0d exp=%h/%0d", i, ob_key[i], ob_idx[i], mem_m[0][e], e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_gapped256();
        sel = 1;
        capture(15, 3, 0);
        checks++; if (cap_full_early !== 0) begin failures++; $display("FAIL gap_early got=%0d exp=0", cap_full_early); end
        checks++; if (w_full !== 1'b1) begin failures++; $display("FAIL gap_full got=%0b exp=1", w_full); end
        collect_pass(0, 0);
        checks++; if (ob_timeout || ob_n !== 15) begin failures++; $display("FAIL gap_count got=%0d exp=15", ob_n); end
        for (int i = 0; i < ob_n && i < 15; i++) begin
            checks++;
            if (ob_key[i] !== mem_m[1][i] || ob_idx[i] !== 4'(i) || ob_last[i] !== (i == nr_sel())) begin
                failures++;
                $display("FAIL gap_key%0d got=%h/%0d exp=%h/%0d", i, ob_key[i], ob_idx[i], mem_m[1][i], i);
            end
        end
        @(negedge clk);
        sel = 0;
    endtask

    task automatic test_abort();
        int hs;
        bit aborted;
        sel = 0;
        capture(11, 1, 0);
        hs = 0; aborted = 0;
        start = 1'b1; dir = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 40 && !aborted; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (w_valid) begin
                if (hs == 3) begin load = 1'b1; aborted = 1; end
                else hs++;
            end
        end
        @(negedge clk);
        load = 1'b0;
        checks++; if (!aborted || w_valid !== 1'b0 || w_key !== '0) begin failures++;
            $display("FAIL abort_valid got=%0b exp=0", w_valid); end
        checks++; if (w_full !== 1'b0 || w_busy !== 1'b1) begin failures++;
            $display("FAIL abort_state full=%0b busy=%0b exp=0,1", w_full, w_busy); end
        capture(11, 2, 0);
        collect_pass(0, 0);
        checks++; if (ob_n !== 11) begin failures++; $display("FAIL abort_count got=%0d exp=11", ob_n); end
        for (int i = 0; i < ob_n && i < 11; i++) begin
            checks++;
            if (ob_key[i] !== mem_m[0][i] || ob_idx[i] !== 4'(i)) begin failures++;
                $display("FAIL abort_key%0d got=%h exp=%h", i, ob_key[i], mem_m[0][i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [127:0] k;
        sel = 0;
        key_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        key_valid = 1'b0;
        checks++; if (w_err !== 1'b1 || w_full !== 1'b1) begin failures++;
            $display("FAIL err_set err=%0b full=%0b exp=1,1", w_err, w_full); end
        collect_pass(0, 0);
        for (int i = 0; i < ob_n && i < 11; i++) begin
            checks++;
            if (ob_key[i] !== mem_m[0][i]) begin failures++;
                $display("FAIL err_keep%0d got=%h exp=%h", i, ob_key[i], mem_m[0][i]); end
        end
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++; if (w_err !== 1'b0 || w_busy !== 1'b1) begin failures++;
            $display("FAIL err_clear err=%0b busy=%0b exp=0,1", w_err, w_busy); end
        for (int i = 0; i < 11; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            mem_m[0][i] = k;
            key_valid = 1'b1; key_in = k; start = (i == 0); dir = 1'b0;
            @(negedge clk);
            key_valid = 1'b0; start = 1'b0;
            if (i == 0) begin
                checks++; if (w_valid !== 1'b0 || w_full !== 1'b0) begin failures++;
                    $display("FAIL fill_start valid=%0b full=%0b exp=0,0", w_valid, w_full); end
            end
        end
        checks++; if (w_full !== 1'b1 || w_err !== 1'b0) begin failures++;
            $display("FAIL err_refill full=%0b err=%0b exp=1,0", w_full, w_err); end
        collect_pass(0, 0);
        checks++; if (ob_n !== 11 || ob_key[0] !== mem_m[0][0] || ob_key[10] !== mem_m[0][10]) begin
            failures++; $display("FAIL err_replay n=%0d key0=%h exp=11,%h", ob_n, ob_key[0], mem_m[0][0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_play();
        int hs;
        sel = 0;
        hs = 0;
        start = 1'b1; dir = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && reset_n; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (w_valid) begin
                if (hs == 3) reset_n = 1'b0;
                else hs++;
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (w_valid !== 0 || w_key !== '0 || w_idx !== 0 || w_last !== 0) begin failures++;
            $display("FAIL rst_out valid=%0b key=%h idx=%0d last=%0b exp=0", w_valid, w_key, w_idx, w_last); end
        checks++; if (w_full !== 0 || w_busy !== 0 || w_err !== 0) begin failures++;
            $display("FAIL rst_flags full=%0b busy=%0b err=%0b exp=0", w_full, w_busy, w_err); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (w_valid !== 0 || w_full !== 0 || w_busy !== 0) begin failures++;
            $display("FAIL rst_start valid=%0b full=%0b busy=%0b exp=0", w_valid, w_full, w_busy); end
        capture(11, 1, 0);
        collect_pass(1, 1);
        checks++; if (ob_n !== 11 || ob_stall_viol !== 0) begin failures++;
            $display("FAIL rst_count n=%0d stall=%0d exp=11,0", ob_n, ob_stall_viol); end
        for (int i = 0; i < ob_n && i < 11; i++) begin
            checks++;
            if (ob_key[i] !== mem_m[0][10 - i] || ob_idx[i] !== 4'(10 - i)) begin failures++;
                $display("FAIL rst_key%0d got=%h exp=%h", i, ob_key[i], mem_m[0][10 - i]); end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fwd128();
        test_rev_backpressure();
        test_gapped256();
        test_abort();
        test_errors();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
